instr_queue: RTL
================

Name: instr_queue

Overview:
- Synchronous FIFO between instruction fetch and i_decode.
- Fetch pushes one i_queue_data_t entry per cycle: instruction word plus its pc and next_pc.
- Decode pops the head entry. The head is presented first-word-fall-through, so i_decode sees it combinationally.
- A flush from branch recovery discards all queued entries.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries (mispredict/redirect).
- wr_en  input  1  fetch push request.
- d_in  input  i_queue_data_t  entry to push: pc[31:0], next_pc[31:0], instr[31:0].
- full  output  1  no free slot; fetch must stall.
- rd_en  input  1  decode pop request.
- d_out  output  i_queue_data_t  head entry; valid only while empty==0.
- empty  output  1  no valid entry.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (async, rst=1):
  - rd_ptr=0, wr_ptr=0, count=0.
  - All storage entries cleared to 0, so d_out=0.
  - empty=1, full=0.
  - Takes effect immediately, without waiting for clk. Any in-flight push or pop is lost.
- Flags:
  - full = (count==DEPTH).
  - empty = (count==0).
  - Both are derived from registered count, with no combinational path from wr_en or rd_en.
- Push:
  - Accepted iff wr_en && !full && !flush.
  - On acceptance, mem[wr_ptr] <= d_in and wr_ptr <= wr_ptr+1.
  - wr_ptr wraps DEPTH-1 -> 0 (natural PTR_W overflow).
- Pop:
  - Accepted iff rd_en && !empty && !flush.
  - On acceptance, rd_ptr <= rd_ptr+1, with the same wrap as wr_ptr.
  - Popped entry contents are left stale in memory.
- d_out = mem[rd_ptr], a combinational read. The new head appears in the cycle after a pop.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop in the same cycle.
- Push while full: ignored. Pointers, count and memory are unchanged, with no overwrite. There is no same-cycle pop-enables-push bypass; full blocks the write even if rd_en is asserted.
- Pop while empty: ignored, with no pointer movement.
- Push and pop while empty:
  - Push accepted, pop ignored, no bypass of d_in to d_out.
  - Next cycle: count=1, empty=0, d_out=that entry.
- Push and pop with 0<count<DEPTH: both accepted; count holds.
- Flush:
  - On the next edge, rd_ptr=wr_ptr=0 and count=0.
  - Has priority over wr_en and rd_en in the same cycle; neither takes effect.
  - Memory contents are not cleared.
- Latency: push to visibility on d_out (if queue was empty) is 1 cycle.
- Storage: DEPTH x $bits(i_queue_data_t) flops. No SRAM macro.

Decomposition:
- Shared package structs holds:
  - i_queue_data_t (pc, next_pc, instr, 32 bits each).
  - Localparam IQ_DEPTH_DEFAULT=8.
- The top of design instantiates instr_queue with DEPTH=IQ_DEPTH_DEFAULT.
- No sub-module. Pointer, counter and memory logic are in a single module: one always_ff for pointers/count with async reset, one always_ff for memory writes.

Test Plan:
- Reset: assert rst mid-cycle with 3 entries queued -> immediately empty=1, full=0, count=0, d_out=0; no pop is visible afterwards.
- Fill/drain order:
  - Push instr 0x00000013, 0x00100093, ..., 8 entries (pc 0x60000000 + 4i) -> count=8, full=1.
  - 9th push ignored.
  - Pop 8 -> d_out pc sequence 0x60000000..0x6000001C in order; then empty=1.
- Wrap: push 5, pop 5, push 6 -> wr_ptr wraps to 3; 6 pops return correct order, pc 0x600000xx continuous; count returns to 0.
- Simultaneous push+pop at count=4 for 10 cycles -> count stays 4; output order preserved.
- Empty push+pop: count=0, wr_en=rd_en=1 with instr 0xDEADBEEF -> next cycle count=1, d_out.instr=0xDEADBEEF.
- Flush priority: count=5, flush=wr_en=rd_en=1 -> next cycle count=0, empty=1; a subsequent push 0x12345678 appears on d_out next cycle.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared types and defaults for the fetch -> decode instruction queue.
package instr_queue_pkg;

    // Architectural word width for pc, next_pc and instruction fields.
    localparam int IQ_XLEN = 32;

    // Default number of queue entries used by the top-level instance.
    localparam int IQ_DEPTH_DEFAULT = 8;

    // One queued fetch result: the instruction and where it came from / goes next.
    typedef struct packed {
        logic [IQ_XLEN-1:0] pc;
        logic [IQ_XLEN-1:0] next_pc;
        logic [IQ_XLEN-1:0] instr;
    } i_queue_data_t;

endpackage : instr_queue_pkg

// File: rtl/instr_queue.sv
// Synchronous FIFO between instruction fetch and decode.
// Head entry is presented first-word-fall-through; flush discards all entries.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            wr_en,
    input  i_queue_data_t   d_in,
    output logic            full,
    input  logic            rd_en,
    output i_queue_data_t   d_out,
    output logic            empty,
    output logic [PTR_W:0]  count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count_nxt;
    logic             push_ok;
    logic             pop_ok;

    i_queue_data_t mem [DEPTH];

    // Flags come only from registered count, so fetch/decode see no
    // combinational path from their own request lines.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Flush overrides both requests; full blocks a push even if a pop is
    // requested in the same cycle (no pop-enables-push bypass).
    assign push_ok = wr_en && !full  && !flush;
    assign pop_ok  = rd_en && !empty && !flush;

    // Next-state computation for pointers and occupancy.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_nxt = count + (PTR_W + 1)'(1);
                2'b01:   count_nxt = count - (PTR_W + 1)'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples its inputs from before the edge.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Entry storage; written only on an accepted push, never cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is deliberately reset so d_out reads zero out of
            // reset; popped and flushed entries are otherwise left stale.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= d_in;
        end
    end

    // First-word-fall-through head: a new head is visible the cycle after a pop.
    assign d_out = mem[rd_ptr];

endmodule : instr_queue
